// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3 convolutional encoder and the 4-state Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 4;
    localparam logic [2:0]  G0_DEF     = 3'b111;
    localparam logic [2:0]  G1_DEF     = 3'b101;

    typedef logic [1:0] state_t;
    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StTail0,
        StTail1
    } enc_state_e;

endpackage

// File: rtl/conv_enc_core.sv
// Combinational K=3 encoder step: (u, st) -> (code symbol, next shift state).
module conv_enc_core
    import viterbi_pkg::*;
#(
    parameter logic [2:0] G0 = G0_DEF,
    parameter logic [2:0] G1 = G1_DEF
) (
    input  logic   u_i,
    input  state_t st_i,
    output sym_t   sym_o,
    output state_t st_next_o
);

    logic [2:0] taps;

    // taps = {u(t), u(t-1), u(t-2)}
    assign taps      = {u_i, st_i};
    assign sym_o     = {^(G0 & taps), ^(G1 & taps)};
    assign st_next_o = {u_i, st_i[1]};

endmodule

// File: rtl/conv_enc_k3.sv
// Rate-1/2 K=3 framed convolutional encoder with two zero tail symbols per frame.
// Optional symbol error injection is enabled by defining CONV_ENC_ERR_INJ_EN.
module conv_enc_k3
    import viterbi_pkg::*;
#(
    parameter logic [2:0]  G0    = G0_DEF,
    parameter logic [2:0]  G1    = G1_DEF,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             data_i,
    input  logic             data_valid_i,
    input  logic             data_last_i,
    output logic             data_ready_o,
    output logic [1:0]       sym_o,
    output logic             sym_valid_o,
    output logic             sym_last_o,
    input  logic             sym_ready_i,
    output logic [CNT_W-1:0] sym_idx_o,
    input  logic             err_en_i,
    input  logic [CNT_W-1:0] err_idx_i,
    input  logic [1:0]       err_mask_i
);

    enc_state_e       state_q;
    state_t           st_q;
    sym_t             sym_q;
    logic             sym_valid_q;
    logic             sym_last_q;
    logic [CNT_W-1:0] sym_idx_q;
    logic [CNT_W-1:0] cnt_q;

    logic   adv;
    logic   in_tail;
    logic   accept;
    logic   load;
    logic   u;
    sym_t   code;
    state_t st_next;
    sym_t   inj_mask;

    assign adv          = !sym_valid_q || sym_ready_i;
    assign in_tail      = (state_q == StTail0) || (state_q == StTail1);
    assign data_ready_o = adv && !in_tail;
    assign accept       = data_valid_i && data_ready_o;
    assign load         = accept || (adv && in_tail);
    assign u            = in_tail ? 1'b0 : data_i;

    conv_enc_core #(
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .u_i       (u),
        .st_i      (st_q),
        .sym_o     (code),
        .st_next_o (st_next)
    );

`ifdef CONV_ENC_ERR_INJ_EN
    assign inj_mask = (err_en_i && (cnt_q == err_idx_i)) ? err_mask_i : 2'b00;
`else
    logic unused_err;
    assign unused_err = ^{err_en_i, err_idx_i, err_mask_i};
    assign inj_mask   = 2'b00;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            st_q        <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            sym_idx_q   <= '0;
            cnt_q       <= '0;
        end else begin
            if (load) begin
                sym_q       <= code ^ inj_mask;
                sym_valid_q <= 1'b1;
                sym_last_q  <= (state_q == StTail1);
                sym_idx_q   <= cnt_q;
                st_q        <= st_next;
                // Counter saturates rather than wrapping on very long frames
                if (state_q == StTail1) begin
                    cnt_q <= '0;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (adv) begin
                sym_valid_q <= 1'b0;
                sym_last_q  <= 1'b0;
            end

            case (state_q)
                StIdle:  if (accept) state_q <= data_last_i ? StTail0 : StData;
                StData:  if (accept && data_last_i) state_q <= StTail0;
                StTail0: if (load) state_q <= StTail1;
                StTail1: if (load) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sym_o       = sym_q;
    assign sym_valid_o = sym_valid_q;
    assign sym_last_o  = sym_last_q;
    assign sym_idx_o   = sym_idx_q;

endmodule

// File: tb/tb_conv_enc_k3.sv
// Scoreboard bench for conv_enc_k3: directed frames with hand-computed code symbols.
module tb_conv_enc_k3;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [1:0]  sym;
        logic        last;
        logic [15:0] idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             data_i;
    logic             data_valid_i;
    logic             data_last_i;
    logic             data_ready_o;
    logic [1:0]       sym_o;
    logic             sym_valid_o;
    logic             sym_last_o;
    logic             sym_ready_i;
    logic [CNT_W-1:0] sym_idx_o;
    logic             err_en_i;
    logic [CNT_W-1:0] err_idx_i;
    logic [1:0]       err_mask_i;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic stall_mode = 1'b0;

    always #5 clk = ~clk;

    conv_enc_k3 dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_last_i  (data_last_i),
        .data_ready_o (data_ready_o),
        .sym_o        (sym_o),
        .sym_valid_o  (sym_valid_o),
        .sym_last_o   (sym_last_o),
        .sym_ready_i  (sym_ready_i),
        .sym_idx_o    (sym_idx_o),
        .err_en_i     (err_en_i),
        .err_idx_i    (err_idx_i),
        .err_mask_i   (err_mask_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic l, input int idx);
        exp_t e;
        e.sym  = s;
        e.last = l;
        e.idx  = idx[15:0];
        exp_q.push_back(e);
    endtask

    // Frame 1,0,1,1 followed by its two tail symbols
    task automatic push_frame_1011();
        push(2'b11, 1'b0, 0);
        push(2'b10, 1'b0, 1);
        push(2'b00, 1'b0, 2);
        push(2'b01, 1'b0, 3);
        push(2'b01, 1'b0, 4);
        push(2'b11, 1'b1, 5);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the bit is taken
    task automatic drive_bit(input logic b, input logic l, output int waits);
        waits        = 0;
        data_valid_i = 1'b1;
        data_i       = b;
        data_last_i  = l;
        #1;
        while (!data_ready_o && waits < 50) begin
            @(posedge clk);
            #2;
            waits++;
        end
        if (waits >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no data_ready_o in %0d cycles required acceptance", waits);
        end
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
    endtask

    task automatic send_1011();
        int w;
        drive_bit(1'b1, 1'b0, w);
        drive_bit(1'b0, 1'b0, w);
        drive_bit(1'b1, 1'b0, w);
        drive_bit(1'b1, 1'b1, w);
    endtask

    task automatic wait_drain(input string name);
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_valid_drop"}, {31'd0, sym_valid_o}, 0);
    endtask

    // sym_ready_i driver: held high, or cycling 1,0,0,1 in stall mode
    initial begin
        logic pat [4];
        int   k = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sym_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                sym_ready_i = pat[k % 4];
                k++;
            end else begin
                sym_ready_i = 1'b1;
            end
        end
    end

    // Monitor: pops on every handshake, and checks outputs hold across stalls
    initial begin
        exp_t        e;
        logic        held_v = 1'b0;
        logic [1:0]  held_sym = '0;
        logic        held_last = 1'b0;
        logic [15:0] held_idx = '0;
        forever begin
            @(negedge clk);
            if (held_v) begin
                check("stall_hold", {13'd0, sym_valid_o, sym_o, sym_last_o, sym_idx_o},
                      {13'd0, 1'b1, held_sym, held_last, held_idx});
            end
            if (sym_valid_o && sym_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_sym: got sym=%b idx=%0d required no symbol",
                             sym_o, sym_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check("sym_last_idx", {13'd0, sym_o, sym_last_o, sym_idx_o},
                          {13'd0, e.sym, e.last, e.idx});
                end
            end
            held_v    = sym_valid_o && !sym_ready_i;
            held_sym  = sym_o;
            held_last = sym_last_o;
            held_idx  = sym_idx_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before timeout");
        $fatal(1);
    end

    initial begin
        int w;
        rst_ni       = 1'b0;
        data_i       = 1'b0;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        err_en_i     = 1'b0;
        err_idx_i    = '0;
        err_mask_i   = 2'b00;

        repeat (2) @(negedge clk);
        check("rst_sym", {30'd0, sym_o}, 0);
        check("rst_valid", {31'd0, sym_valid_o}, 0);
        check("rst_last", {31'd0, sym_last_o}, 0);
        check("rst_idx", {16'd0, sym_idx_o}, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #1;
        check("rst_ready", {31'd0, data_ready_o}, 1);

        // Basic frame at full rate
        push_frame_1011();
        send_1011();
        wait_drain("frame1011");

        // Single-bit frame; ready low while both tails load
        push(2'b11, 1'b0, 0);
        push(2'b10, 1'b0, 1);
        push(2'b11, 1'b1, 2);
        @(posedge clk);
        #1;
        drive_bit(1'b1, 1'b1, w);
        check("single_ready_t0", {31'd0, data_ready_o}, 0);
        @(posedge clk);
        #1;
        check("single_ready_t1", {31'd0, data_ready_o}, 0);
        @(posedge clk);
        #1;
        check("single_ready_idle", {31'd0, data_ready_o}, 1);
        wait_drain("single");

        // Same frame under downstream backpressure
        stall_mode = 1'b1;
        @(posedge clk);
        #1;
        push_frame_1011();
        send_1011();
        wait_drain("stall");
        stall_mode = 1'b0;

        // Back-to-back frames "1" and "0"
        @(posedge clk);
        #1;
        push(2'b11, 1'b0, 0);
        push(2'b10, 1'b0, 1);
        push(2'b11, 1'b1, 2);
        push(2'b00, 1'b0, 0);
        push(2'b00, 1'b0, 1);
        push(2'b00, 1'b1, 2);
        drive_bit(1'b1, 1'b1, w);
        drive_bit(1'b0, 1'b1, w);
        check("b2b_wait", w, 2);
        wait_drain("b2b");

        // Reset mid-frame after two bits, then a fresh frame 1,1
        @(posedge clk);
        #1;
        push(2'b11, 1'b0, 0);
        push(2'b01, 1'b0, 1);
        drive_bit(1'b1, 1'b0, w);
        drive_bit(1'b1, 1'b0, w);
        @(negedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_sym", {30'd0, sym_o}, 0);
        check("midrst_valid", {31'd0, sym_valid_o}, 0);
        check("midrst_last", {31'd0, sym_last_o}, 0);
        check("midrst_idx", {16'd0, sym_idx_o}, 0);
        check("midrst_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        push(2'b11, 1'b0, 0);
        push(2'b01, 1'b0, 1);
        push(2'b01, 1'b0, 2);
        push(2'b11, 1'b1, 3);
        drive_bit(1'b1, 1'b0, w);
        drive_bit(1'b1, 1'b1, w);
        wait_drain("after_rst");

        // Error injection on symbol index 2
        @(posedge clk);
        #1;
        err_en_i   = 1'b1;
        err_idx_i  = 16'd2;
        err_mask_i = 2'b01;
        push(2'b11, 1'b0, 0);
        push(2'b10, 1'b0, 1);
`ifdef CONV_ENC_ERR_INJ_EN
        push(2'b01, 1'b0, 2);
`else
        push(2'b00, 1'b0, 2);
`endif
        push(2'b01, 1'b0, 3);
        push(2'b01, 1'b0, 4);
        push(2'b11, 1'b1, 5);
        send_1011();
        wait_drain("err_inj");
        err_en_i = 1'b0;

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
